// File: rtl/cci_test_flow_pkg.sv
// Shared types and defaults for the CCI-P test flow-control scheduler.
package cci_test_flow_pkg;

  localparam int MAX_ACTIVE_LINES_DEF = 512;
  localparam int CNT_W_DEF            = $clog2(MAX_ACTIVE_LINES_DEF) + 1;
  localparam int SLACK_LINES_DEF      = 16;

  typedef logic [CNT_W_DEF-1:0] t_active_cnt;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } t_flow_state;

endpackage

// File: rtl/cci_test_flow_throttle.sv
// Duty-cycle throttle: free-running phase counter, thr high for the first
// on_cycles of every period.
module cci_test_flow_throttle #(
  parameter int THROTTLE_BITS = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [THROTTLE_BITS-1:0] period,
  input  logic [THROTTLE_BITS-1:0] on_cycles,
  output logic                     thr
);

  logic [THROTTLE_BITS-1:0] phase_q, phase_d;
  logic [THROTTLE_BITS:0]   phase_inc;

  // Wrap on >= so a period lowered below the current phase recovers at once.
  always_comb begin
    phase_inc = {1'b0, phase_q} + (THROTTLE_BITS+1)'(1);
    phase_d   = phase_q;
    if (period == '0) begin
      phase_d = '0;
    end else if (phase_inc >= {1'b0, period}) begin
      phase_d = '0;
    end else begin
      phase_d = phase_inc[THROTTLE_BITS-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign thr = (period != '0) && (phase_q < on_cycles);

endmodule

// File: rtl/cci_test_flow_ctrl.sv
// Drives forced almost-full on c0/c1 from line limits, a duty-cycle throttle
// and a drain handshake; counts cycles spent with either channel forced.
module cci_test_flow_ctrl
  import cci_test_flow_pkg::*;
#(
  parameter int          MAX_ACTIVE_LINES = MAX_ACTIVE_LINES_DEF,
  parameter int          CNT_W            = $clog2(MAX_ACTIVE_LINES) + 1,
  parameter int          SLACK_LINES      = SLACK_LINES_DEF,
  parameter int          THROTTLE_BITS    = 8,
  parameter logic [31:0] STAT_INIT        = 32'd0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cfg_enable,
  input  logic [CNT_W-1:0]         cfg_c0_max_lines,
  input  logic [CNT_W-1:0]         cfg_c1_max_lines,
  input  logic [THROTTLE_BITS-1:0] cfg_throttle_period,
  input  logic [THROTTLE_BITS-1:0] cfg_throttle_on,
  input  logic                     drain_req,
  output logic                     drain_done,
  input  logic [CNT_W-1:0]         c0ActiveLines,
  input  logic [CNT_W-1:0]         c1ActiveLines,
  output logic                     c0ForceAlmFull,
  output logic                     c1ForceAlmFull,
  output logic [31:0]              throttle_cycles
);

  t_flow_state state_q, state_d;
  logic        zero_seen_q, zero_seen_d;
  logic        c0_force_q, c0_force_d;
  logic        c1_force_q, c1_force_d;
  logic        drain_done_q, drain_done_d;
  logic [31:0] throttle_cycles_q, throttle_cycles_d;
  logic        thr, lim_c0, lim_c1, lines_zero;
  logic [CNT_W:0] c0_sum, c1_sum;

  cci_test_flow_throttle #(.THROTTLE_BITS(THROTTLE_BITS)) u_thr (
    .clk       (clk),
    .reset     (reset),
    .period    (cfg_throttle_period),
    .on_cycles (cfg_throttle_on),
    .thr       (thr)
  );

  // One extra bit so ActiveLines + slack can never wrap below the limit.
  always_comb begin
    c0_sum = {1'b0, c0ActiveLines} + (CNT_W+1)'(SLACK_LINES);
    c1_sum = {1'b0, c1ActiveLines} + (CNT_W+1)'(SLACK_LINES);
    lim_c0 = cfg_enable && (cfg_c0_max_lines != '0) && (c0_sum >= {1'b0, cfg_c0_max_lines});
    lim_c1 = cfg_enable && (cfg_c1_max_lines != '0) && (c1_sum >= {1'b0, cfg_c1_max_lines});
  end

  // Two consecutive zero samples in ST_DRAIN are required to ride out tracker lag.
  always_comb begin
    state_d     = state_q;
    zero_seen_d = 1'b0;
    lines_zero  = (c0ActiveLines == '0) && (c1ActiveLines == '0);
    unique case (state_q)
      ST_RUN:   if (drain_req) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (!drain_req) begin
          state_d = ST_RUN;
        end else if (lines_zero) begin
          if (zero_seen_q) state_d = ST_DONE;
          else zero_seen_d = 1'b1;
        end
      end
      ST_DONE:  if (!drain_req) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // Forces key off the next state so a drain request takes effect one cycle later.
  always_comb begin
    c0_force_d        = (state_d != ST_RUN) || thr || lim_c0;
    c1_force_d        = (state_d != ST_RUN) || thr || lim_c1;
    drain_done_d      = (state_d == ST_DONE);
    throttle_cycles_d = throttle_cycles_q;
    if ((c0_force_q || c1_force_q) && (throttle_cycles_q != 32'hFFFF_FFFF)) begin
      throttle_cycles_d = throttle_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= ST_RUN;
      zero_seen_q       <= 1'b0;
      c0_force_q        <= 1'b0;
      c1_force_q        <= 1'b0;
      drain_done_q      <= 1'b0;
      throttle_cycles_q <= STAT_INIT;
    end else begin
      state_q           <= state_d;
      zero_seen_q       <= zero_seen_d;
      c0_force_q        <= c0_force_d;
      c1_force_q        <= c1_force_d;
      drain_done_q      <= drain_done_d;
      throttle_cycles_q <= throttle_cycles_d;
    end
  end

  assign c0ForceAlmFull  = c0_force_q;
  assign c1ForceAlmFull  = c1_force_q;
  assign drain_done      = drain_done_q;
  assign throttle_cycles = throttle_cycles_q;

endmodule
